// File: rtl/bp_me_cache_pkt_arbiter.sv
// bp_me_cache_pkt_arbiter
// Shares one bsg_cache packet port among num_req_p requesters. Commands are
// granted round-robin, optionally locked to one requester for a burst, and an
// in-order owner FIFO steers each cache response back to its issuer.
//
// state    | meaning
// UNLOCKED | grant to first valid requester scanning up from rr_ptr_r
// LOCKED   | only lock_id_r may issue; other requesters wait
module bp_me_cache_pkt_arbiter #(
   parameter int num_req_p     = 2,
   parameter int paddr_width_p = 40,
   parameter int dword_width_p = 64,
   parameter int outstanding_p = 4,
   parameter int pkt_width_lp  = 6 + paddr_width_p + dword_width_p + (dword_width_p >> 3),
   parameter int lg_req_lp     = (num_req_p <= 1) ? 1 : $clog2(num_req_p)
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   input  logic [num_req_p*pkt_width_lp-1:0] req_pkt_i,
   input  logic [num_req_p-1:0]              req_v_i,
   input  logic [num_req_p-1:0]              req_lock_i,
   output logic [num_req_p-1:0]              req_ready_o,
   output logic [dword_width_p-1:0]          req_data_o,
   output logic [num_req_p-1:0]              req_v_o,
   input  logic [num_req_p-1:0]              req_yumi_i,
   output logic [pkt_width_lp-1:0]           cache_pkt_o,
   output logic                              v_o,
   input  logic                              ready_i,
   input  logic [dword_width_p-1:0]          data_i,
   input  logic                              v_i,
   output logic                              yumi_o,
   output logic                              err_o
);

   localparam int cnt_width_lp = (outstanding_p + 1 <= 1) ? 1 : $clog2(outstanding_p + 1);
   localparam int ptr_width_lp = (outstanding_p <= 1) ? 1 : $clog2(outstanding_p);
   localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(outstanding_p);
   localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(outstanding_p - 1);
   localparam logic [lg_req_lp-1:0]    last_req_lp = lg_req_lp'(num_req_p - 1);

   typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

   lock_state_e             state_r;
   logic [lg_req_lp-1:0]    lock_id_r;
   logic [lg_req_lp-1:0]    rr_ptr_r;
   logic [lg_req_lp-1:0]    fifo_mem_r [outstanding_p];
   logic [ptr_width_lp-1:0] wr_ptr_r;
   logic [ptr_width_lp-1:0] rd_ptr_r;
   logic [cnt_width_lp-1:0] count_r;
   logic                    err_r;

   logic                    grant_v;
   logic [lg_req_lp-1:0]    grant_id;
   logic [lg_req_lp-1:0]    cand_id;
   logic [lg_req_lp-1:0]    head_id;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic                    accept;
   logic                    pop;

   assign fifo_empty = (count_r == '0);
   assign fifo_full  = (count_r == full_cnt_lp);
   assign head_id    = fifo_mem_r[rd_ptr_r];

   // Pick the granted requester: locked owner, or round-robin scan from rr_ptr_r.
   always_comb begin
      grant_v  = 1'b0;
      grant_id = '0;
      cand_id  = '0;
      if (state_r == LOCKED) begin
         grant_v  = req_v_i[lock_id_r];
         grant_id = lock_id_r;
      end else begin
         // Scan downward so the nearest requester above rr_ptr_r wins last.
         for (int i = num_req_p - 1; i >= 0; i--) begin
            cand_id = lg_req_lp'((int'(rr_ptr_r) + i) % num_req_p);
            if (req_v_i[cand_id]) begin
               grant_v  = 1'b1;
               grant_id = cand_id;
            end
         end
      end
   end

   // Command handshake; full uses the registered count so a same-cycle pop never frees a slot.
   always_comb begin
      v_o         = reset_n_i & grant_v & ~fifo_full;
      accept      = v_o & ready_i;
      req_ready_o = '0;
      if (accept) begin
         req_ready_o[grant_id] = 1'b1;
      end
      cache_pkt_o = grant_v ? req_pkt_i[int'(grant_id)*pkt_width_lp +: pkt_width_lp] : '0;
   end

   // Route the response to the FIFO head owner; drain ownerless responses.
   always_comb begin
      req_v_o = '0;
      yumi_o  = 1'b0;
      if (reset_n_i && v_i) begin
         if (!fifo_empty) begin
            req_v_o[head_id] = 1'b1;
            yumi_o           = req_yumi_i[head_id];
         end else begin
            yumi_o = 1'b1;
         end
      end
   end

   assign req_data_o = data_i;
   assign pop        = yumi_o & ~fifo_empty;
   assign err_o      = err_r & reset_n_i;

   // Lock FSM and round-robin pointer; both advance only on an accept.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r   <= UNLOCKED;
         lock_id_r <= '0;
         rr_ptr_r  <= '0;
      end else if (accept) begin
         rr_ptr_r <= (grant_id == last_req_lp) ? '0 : grant_id + 1'b1;
         if (req_lock_i[grant_id]) begin
            state_r   <= LOCKED;
            lock_id_r <= grant_id;
         end else begin
            state_r <= UNLOCKED;
         end
      end
   end

   // Owner FIFO: push grant ID on accept, pop on consumed response.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         for (int i = 0; i < outstanding_p; i++) begin
            fifo_mem_r[i] <= '0;
         end
      end else begin
         if (accept) begin
            fifo_mem_r[wr_ptr_r] <= grant_id;
            wr_ptr_r             <= (wr_ptr_r == last_ptr_lp) ? '0 : wr_ptr_r + 1'b1;
         end
         if (pop) begin
            rd_ptr_r <= (rd_ptr_r == last_ptr_lp) ? '0 : rd_ptr_r + 1'b1;
         end
         case ({accept, pop})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky error: a response arrived with no recorded owner.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         err_r <= 1'b0;
      end else if (yumi_o && fifo_empty) begin
         err_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bp_me_cache_pkt_arbiter.sv
// Scoreboard bench for bp_me_cache_pkt_arbiter: stimulus pushes expected
// accepts, responses and point probes; one monitor at negedge compares them.
module tb_bp_me_cache_pkt_arbiter;

   localparam int NR = 2;
   localparam int PW = 6 + 40 + 64 + 8;
   localparam logic [63:0] RSP_MASK = 64'h5A5A_5A5A_5A5A_5A5A;

   localparam logic [3:0] SIG_V    = 4'd0;
   localparam logic [3:0] SIG_RDY  = 4'd1;
   localparam logic [3:0] SIG_REQV = 4'd2;
   localparam logic [3:0] SIG_YUMI = 4'd3;
   localparam logic [3:0] SIG_ERR  = 4'd4;
   localparam logic [3:0] SIG_SB   = 4'd5;

   typedef struct packed {logic [PW-1:0] pkt; logic lock;} rq_t;
   typedef struct packed {logic [7:0] r; logic [7:0] n;} rn_t;
   typedef struct packed {logic [127:0] nm; logic [3:0] sig; logic [127:0] req;} probe_t;

   logic               clk = 1'b0;
   logic               reset_n_i;
   logic [NR*PW-1:0]   req_pkt_i;
   logic [NR-1:0]      req_v_i;
   logic [NR-1:0]      req_lock_i;
   logic [NR-1:0]      req_ready_o;
   logic [63:0]        req_data_o;
   logic [NR-1:0]      req_v_o;
   logic [NR-1:0]      req_yumi_i;
   logic [PW-1:0]      cache_pkt_o;
   logic               v_o;
   logic               ready_i;
   logic [63:0]        data_i;
   logic               v_i;
   logic               yumi_o;
   logic               err_o;

   rq_t          rq0 [$];
   rq_t          rq1 [$];
   rn_t          exp_acc_q [$];
   rn_t          exp_rsp_q [$];
   probe_t       probe_q [$];
   logic [63:0]  cache_q [$];
   logic         cache_auto;
   logic         rsp_ready;
   int           n_checks = 0;
   int           n_pass   = 0;

   bp_me_cache_pkt_arbiter dut (
      .clk_i       (clk),
      .reset_n_i   (reset_n_i),
      .req_pkt_i   (req_pkt_i),
      .req_v_i     (req_v_i),
      .req_lock_i  (req_lock_i),
      .req_ready_o (req_ready_o),
      .req_data_o  (req_data_o),
      .req_v_o     (req_v_o),
      .req_yumi_i  (req_yumi_i),
      .cache_pkt_o (cache_pkt_o),
      .v_o         (v_o),
      .ready_i     (ready_i),
      .data_i      (data_i),
      .v_i         (v_i),
      .yumi_o      (yumi_o),
      .err_o       (err_o)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mk_data(input int r, input int n);
      return 64'hD0D0_0000_0000_0000 | (64'(r) << 16) | 64'(n);
   endfunction

   function automatic logic [63:0] rsp_data(input int r, input int n);
      return mk_data(r, n) ^ RSP_MASK;
   endfunction

   function automatic logic [PW-1:0] mk_pkt(input int r, input int n);
      return {6'(r + 1), 40'(n * 16 + r), mk_data(r, n), 8'hFF};
   endfunction

   task automatic chk(input logic [127:0] nm, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %0s: got %0h, need %0h", nm, act, req);
   endtask

   // Monitor: compare accepts, delivered responses and queued probes.
   always @(negedge clk) begin : mon
      rn_t          e;
      probe_t       p;
      logic [127:0] act;
      logic [1:0]   oh;
      if (v_o && ready_i) begin
         if (exp_acc_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_accept: got req_ready_o %b, need no accept", req_ready_o);
         end else begin
            e  = exp_acc_q.pop_front();
            oh = 2'b01 << e.r;
            chk("acc_grant", 128'(req_ready_o), 128'(oh));
            chk("acc_pkt", 128'(cache_pkt_o), 128'(mk_pkt(int'(e.r), int'(e.n))));
         end
      end
      if ((req_v_o & req_yumi_i) != '0) begin
         if (exp_rsp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_rsp: got req_v_o %b, need no response", req_v_o);
         end else begin
            e  = exp_rsp_q.pop_front();
            oh = 2'b01 << e.r;
            chk("rsp_owner", 128'(req_v_o), 128'(oh));
            chk("rsp_data", 128'(req_data_o), 128'(rsp_data(int'(e.r), int'(e.n))));
         end
      end
      while (probe_q.size() != 0) begin
         p = probe_q.pop_front();
         case (p.sig)
            SIG_V:    act = 128'(v_o);
            SIG_RDY:  act = 128'(req_ready_o);
            SIG_REQV: act = 128'(req_v_o);
            SIG_YUMI: act = 128'(yumi_o);
            SIG_ERR:  act = 128'(err_o);
            default:  act = 128'(exp_acc_q.size() + exp_rsp_q.size() + rq0.size() + rq1.size());
         endcase
         chk(p.nm, act, p.req);
      end
   end

   task automatic probe(input logic [127:0] nm, input logic [3:0] sig, input logic [127:0] req);
      probe_t p;
      p.nm  = nm;
      p.sig = sig;
      p.req = req;
      probe_q.push_back(p);
   endtask

   task automatic issue(input int r, input int n, input logic lock);
      rq_t e;
      e.pkt  = mk_pkt(r, n);
      e.lock = lock;
      if (r == 0) rq0.push_back(e);
      else        rq1.push_back(e);
   endtask

   task automatic exp_acc(input int r, input int n);
      rn_t e;
      e.r = 8'(r);
      e.n = 8'(n);
      exp_acc_q.push_back(e);
   endtask

   task automatic exp_rsp(input int r, input int n);
      rn_t e;
      e.r = 8'(r);
      e.n = 8'(n);
      exp_rsp_q.push_back(e);
   endtask

   task automatic drive_inputs();
      req_v_i[0]    = (rq0.size() != 0);
      req_lock_i[0] = (rq0.size() != 0) ? rq0[0].lock : 1'b0;
      req_pkt_i[PW-1:0] = (rq0.size() != 0) ? rq0[0].pkt : '0;
      req_v_i[1]    = (rq1.size() != 0);
      req_lock_i[1] = (rq1.size() != 0) ? rq1[0].lock : 1'b0;
      req_pkt_i[2*PW-1:PW] = (rq1.size() != 0) ? rq1[0].pkt : '0;
      req_yumi_i = {NR{rsp_ready}};
      if (cache_auto) begin
         v_i    = (cache_q.size() != 0);
         data_i = (cache_q.size() != 0) ? cache_q[0] : '0;
      end
   endtask

   // One clock: sample handshakes at negedge, update requester/cache models after posedge.
   task automatic step();
      logic [NR-1:0] rdy;
      logic          acc;
      logic          popped;
      logic [PW-1:0] pkt;
      @(negedge clk);
      rdy    = req_ready_o;
      acc    = v_o & ready_i;
      popped = yumi_o;
      pkt    = cache_pkt_o;
      @(posedge clk);
      #1;
      if (rdy[0] && rq0.size() != 0) void'(rq0.pop_front());
      if (rdy[1] && rq1.size() != 0) void'(rq1.pop_front());
      if (cache_auto) begin
         if (popped && cache_q.size() != 0) void'(cache_q.pop_front());
         if (acc) cache_q.push_back(pkt[71:8] ^ RSP_MASK);
      end
      drive_inputs();
   endtask

   task automatic drain(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (exp_acc_q.size() == 0 && exp_rsp_q.size() == 0 && cache_q.size() == 0 &&
             rq0.size() == 0 && rq1.size() == 0) break;
         step();
      end
   endtask

   initial begin
      reset_n_i  = 1'b1;
      ready_i    = 1'b0;
      v_i        = 1'b0;
      data_i     = '0;
      req_v_i    = '0;
      req_lock_i = '0;
      req_pkt_i  = '0;
      req_yumi_i = '0;
      cache_auto = 1'b0;
      rsp_ready  = 1'b1;
      drive_inputs();
      #1 reset_n_i = 1'b0;

      // reset: outputs forced low even with requests and a response pending
      for (int n = 0; n < 4; n++) begin
         issue(0, n, 1'b0);
         issue(1, n, 1'b0);
         exp_acc(0, n); exp_rsp(0, n);
         exp_acc(1, n); exp_rsp(1, n);
      end
      ready_i = 1'b1;
      v_i     = 1'b1;
      data_i  = 64'hBAD0;
      drive_inputs();
      probe("rst_v_o", SIG_V, 0);
      probe("rst_ready", SIG_RDY, 0);
      probe("rst_req_v", SIG_REQV, 0);
      probe("rst_yumi", SIG_YUMI, 0);
      probe("rst_err", SIG_ERR, 0);
      step();
      step();

      // round-robin: alternating grants, responses one cycle later
      v_i        = 1'b0;
      data_i     = '0;
      cache_auto = 1'b1;
      reset_n_i  = 1'b1;
      drive_inputs();
      drain(40);

      // lock: eight contiguous grants to req0, then req1
      for (int n = 10; n < 18; n++) begin
         issue(0, n, n < 17);
         exp_acc(0, n); exp_rsp(0, n);
      end
      issue(1, 10, 1'b0);
      exp_acc(1, 10); exp_rsp(1, 10);
      drive_inputs();
      drain(40);

      // lock held while owner idle: req1 must not be issued
      issue(0, 20, 1'b1);
      issue(1, 20, 1'b0);
      exp_acc(0, 20); exp_rsp(0, 20);
      drive_inputs();
      step();
      probe("lock_idle_v_o", SIG_V, 0);
      probe("lock_idle_ready", SIG_RDY, 0);
      step();
      probe("lock_idle_v_o2", SIG_V, 0);
      step();
      issue(0, 21, 1'b0);
      exp_acc(0, 21); exp_rsp(0, 21);
      exp_acc(1, 20); exp_rsp(1, 20);
      drive_inputs();
      drain(20);

      // full: four accepts, then stall; a pop frees a slot only next cycle
      cache_auto = 1'b0;
      v_i        = 1'b0;
      data_i     = '0;
      for (int n = 30; n < 36; n++) begin
         issue(0, n, 1'b0);
         exp_acc(0, n);
      end
      drive_inputs();
      repeat (4) step();
      probe("full_v_o", SIG_V, 0);
      probe("full_ready", SIG_RDY, 0);
      step();
      probe("full_v_o2", SIG_V, 0);
      v_i    = 1'b1;
      data_i = rsp_data(0, 30);
      exp_rsp(0, 30);
      probe("full_pop_v_o", SIG_V, 0);
      probe("full_pop_yumi", SIG_YUMI, 1);
      step();
      v_i    = 1'b0;
      data_i = '0;
      probe("after_pop_v_o", SIG_V, 1);
      step();
      probe("refull_v_o", SIG_V, 0);

      // back-pressure: head held while requester withholds yumi
      v_i       = 1'b1;
      data_i    = rsp_data(0, 31);
      rsp_ready = 1'b0;
      drive_inputs();
      repeat (3) begin
         probe("bp_yumi", SIG_YUMI, 0);
         probe("bp_req_v", SIG_REQV, 1);
         step();
      end
      rsp_ready = 1'b1;
      drive_inputs();
      exp_rsp(0, 31);
      probe("bp_rel_yumi", SIG_YUMI, 1);
      step();
      v_i    = 1'b0;
      data_i = '0;
      step();
      for (int n = 32; n < 36; n++) begin
         v_i    = 1'b1;
         data_i = rsp_data(0, n);
         exp_rsp(0, n);
         step();
      end
      v_i    = 1'b0;
      data_i = '0;
      drive_inputs();

      // spurious response with empty FIFO
      v_i    = 1'b1;
      data_i = 64'h1234;
      probe("spur_yumi", SIG_YUMI, 1);
      probe("spur_req_v", SIG_REQV, 0);
      probe("spur_err_now", SIG_ERR, 0);
      step();
      v_i    = 1'b0;
      data_i = '0;
      probe("spur_err", SIG_ERR, 1);
      step();
      probe("spur_err_held", SIG_ERR, 1);
      step();

      // reset with three packets in flight
      for (int n = 40; n < 44; n++) issue(1, n, 1'b0);
      exp_acc(1, 40); exp_acc(1, 41); exp_acc(1, 42);
      drive_inputs();
      repeat (3) step();
      ready_i   = 1'b0;
      issue(0, 50, 1'b0);
      v_i       = 1'b1;
      data_i    = rsp_data(1, 40);
      reset_n_i = 1'b0;
      drive_inputs();
      probe("rf_v_o", SIG_V, 0);
      probe("rf_ready", SIG_RDY, 0);
      probe("rf_req_v", SIG_REQV, 0);
      probe("rf_yumi", SIG_YUMI, 0);
      probe("rf_err", SIG_ERR, 0);
      step();
      reset_n_i = 1'b1;
      v_i       = 1'b0;
      data_i    = '0;
      ready_i   = 1'b1;
      exp_acc(0, 50);
      exp_acc(1, 43);
      drive_inputs();
      step();
      step();
      v_i    = 1'b1;
      data_i = rsp_data(0, 50);
      exp_rsp(0, 50);
      step();
      data_i = rsp_data(1, 43);
      exp_rsp(1, 43);
      step();
      v_i    = 1'b0;
      data_i = '0;
      drive_inputs();
      probe("rf_err_clean", SIG_ERR, 0);
      probe("sb_leftover", SIG_SB, 0);
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
